// File: rtl/arith_pkg.sv
// Shared arithmetic constants for the datapath adder cells.
package arith_pkg;

  // Adder cells are purely combinational unless a retimed build asks otherwise.
  localparam bit ADDER_REGISTERED = 1'b0;

endpackage

// File: rtl/half_adder.sv
// Half adder: propagate (s) and generate (c) terms of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder built from two half adders, with an optional output
// register stage for pipelined or retimed datapaths.
module full_adder
  import arith_pkg::*;
#(
  parameter bit REGISTERED = ADDER_REGISTERED
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic Cout
);

  logic p;
  logic g;
  logic s_comb;
  logic c2;
  logic c_comb;

  half_adder u_ha1 (
    .a (A),
    .b (B),
    .s (p),
    .c (g)
  );

  half_adder u_ha2 (
    .a (p),
    .b (Cin),
    .s (s_comb),
    .c (c2)
  );

  // Carry out when both addends are set, or a propagated bit meets the carry in.
  assign c_comb = g | c2;

  if (REGISTERED) begin : g_reg
    // Output stage: synchronous reset clears outputs; otherwise one-cycle latency.
    always_ff @(posedge clk) begin
      if (reset) begin
        sum  <= 1'b0;
        Cout <= 1'b0;
      end else begin
        sum  <= s_comb;
        Cout <= c_comb;
      end
    end
  end else begin : g_comb
    assign sum  = s_comb;
    assign Cout = c_comb;

    // clk and reset have no role in the combinational build.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: combinational truth table, clock independence,
// registered latency/reset behaviour and a 64-slice ripple chain.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ca, cb, ccin, creset;
  logic csum, ccout;
  logic ra, rb, rcin, rreset;
  logic rsum, rcout;
  logic [63:0] xa, xb, xs;
  logic [64:0] xc;

  int checks = 0;
  int failures = 0;

  full_adder #(.REGISTERED(1'b0)) dut_c (
    .clk(clk), .reset(creset), .A(ca), .B(cb), .Cin(ccin), .sum(csum), .Cout(ccout)
  );

  full_adder #(.REGISTERED(1'b1)) dut_r (
    .clk(clk), .reset(rreset), .A(ra), .B(rb), .Cin(rcin), .sum(rsum), .Cout(rcout)
  );

  assign xc[0] = 1'b0;
  for (genvar i = 0; i < 64; i++) begin : g_rip
    full_adder #(.REGISTERED(1'b0)) u_fa (
      .clk(clk), .reset(creset), .A(xa[i]), .B(xb[i]), .Cin(xc[i]),
      .sum(xs[i]), .Cout(xc[i+1])
    );
  end

  // Reference: the two-bit arithmetic sum of three bits.
  function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
    int total;
    total = int'(a) + int'(b) + int'(c);
    return total[1:0];
  endfunction

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={Cout,sum}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check65(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  rexp;
    logic [64:0] wide;

    ca = 1'b0; cb = 1'b0; ccin = 1'b0; creset = 1'b0;
    ra = 1'b0; rb = 1'b0; rcin = 1'b0; rreset = 1'b1;
    xa = '0; xb = '0;

    // Exhaustive truth table, combinational build.
    for (int v = 0; v < 8; v++) begin
      {ca, cb, ccin} = 3'(v);
      #1;
      check2($sformatf("tt_%0d", v), {ccout, csum}, ref_add(ca, cb, ccin));
    end
    // Spot values named directly.
    {ca, cb, ccin} = 3'b111; #1; check2("tt_111_const", {ccout, csum}, 2'b11);
    {ca, cb, ccin} = 3'b100; #1; check2("tt_100_const", {ccout, csum}, 2'b01);

    // Random combinational patterns.
    for (int k = 0; k < 16; k++) begin
      ca = 1'($urandom); cb = 1'($urandom); ccin = 1'($urandom);
      #1;
      check2("comb_rand", {ccout, csum}, ref_add(ca, cb, ccin));
    end

    // clk/reset must not disturb the combinational build.
    ca = 1'b1; cb = 1'b1; ccin = 1'b0;
    for (int k = 0; k < 8; k++) begin
      creset = ~creset;
      #3;
      check2("clk_indep", {ccout, csum}, 2'b10);
    end
    creset = 1'b0;

    // 64-slice ripple chain.
    xa = 64'hFFFF_FFFF_FFFF_FFFF; xb = 64'd1; #10;
    check65("rip_all_ones", xc[64:64] == 1'b1 ? {1'b1, xs} : {1'b0, xs}, 65'h1_0000_0000_0000_0000);
    xa = 64'h7FFF_FFFF_FFFF_FFFF; xb = 64'd1; #10;
    check65("rip_msb", {xc[64], xs}, 65'h0_8000_0000_0000_0000);
    for (int k = 0; k < 100; k++) begin
      xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
      #10;
      wide = {1'b0, xa} + {1'b0, xb};
      check65("rip_rand", {xc[64], xs}, wide);
    end

    // Registered build: reset edge clears outputs.
    @(posedge clk); #1;
    check2("reg_reset", {rcout, rsum}, 2'b00);

    // One-cycle latency: nothing before the edge, result after it.
    @(negedge clk);
    rreset = 1'b0; ra = 1'b1; rb = 1'b0; rcin = 1'b1;
    #1;
    check2("reg_not_before", {rcout, rsum}, 2'b00);
    @(posedge clk); #1;
    check2("reg_latency", {rcout, rsum}, 2'b10);

    // Reset in the middle of a stream.
    @(negedge clk);
    ra = 1'b1; rb = 1'b1; rcin = 1'b1;
    @(posedge clk); #1;
    check2("reg_hold_111", {rcout, rsum}, 2'b11);
    @(negedge clk);
    rreset = 1'b1;
    @(posedge clk); #1;
    check2("reg_mid_reset", {rcout, rsum}, 2'b00);
    @(negedge clk);
    rreset = 1'b0;
    #1;
    check2("reg_after_deassert_pre", {rcout, rsum}, 2'b00);
    @(posedge clk); #1;
    check2("reg_after_deassert", {rcout, rsum}, 2'b11);

    // Random registered stream with occasional reset.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ra = 1'($urandom); rb = 1'($urandom); rcin = 1'($urandom);
      rreset = ($urandom_range(0, 5) == 0);
      rexp = rreset ? 2'b00 : ref_add(ra, rb, rcin);
      @(posedge clk); #1;
      check2("reg_rand", {rcout, rsum}, rexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
